hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter: FLUSH_CYCLES, default 2, number of consecutive flush cycles after a taken jump (legal range 1..7).
REQ-002 SHALL have parameter: CNT_WIDTH, default 32, width of the stall performance counter.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- dec_valid_in  in  1  decode stage holds a valid instruction.
- dec_rs1_in / dec_rs2_in  in  5  decode source register indices.
- dec_uses_rs1_in / dec_uses_rs2_in  in  1  instruction reads rs1/rs2.
- exe_forwarding_in / mem_forwarding_in / wb_forwarding_in  in  38  {valid[37], rd[36:32], data[31:0]}.
- exe_is_load_in  in  1  instruction in EXE is a load (data not yet available).
- mem_busy_in  in  1  memory stage cannot accept/complete this cycle.
- jump_valid_in  in  1  taken jump/branch resolved this cycle.
- stall_fetch_out / stall_decode_out  out  1  hold stage registers.
- bubble_exe_out  out  1  insert NOP into EXE.
- flush_fetch_out / flush_decode_out  out  1  invalidate stage contents.
- fwd_sel_rs1_out / fwd_sel_rs2_out  out  2  operand source: 0 regfile, 1 EXE, 2 MEM, 3 WB.
- state_out  out  2  current FSM state.
- stall_count_out  out  CNT_WIDTH  cycles with stall_decode_out high.

Function
REQ-004 FSM states SHALL be RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3, exposed on state_out.
REQ-005 A source match SHALL require forwarding valid=1, rd!=0, rd==rsN, and dec_uses_rsN_in=1.
REQ-006 fwd_sel_rsN_out SHALL be combinational with priority EXE>MEM>WB, and 0 when no match.
REQ-007 Load-use hazard SHALL be: dec_valid_in & exe_is_load_in & an EXE match on either used source.
REQ-008 In RUN, a load-use hazard SHALL assert stall_fetch, stall_decode and bubble_exe in the same cycle, with next state LOAD_STALL.
REQ-009 LOAD_STALL SHALL last exactly 1 cycle with all stall outputs low, then return to RUN; no re-detection SHALL occur in this cycle.
REQ-010 mem_busy_in=1 in RUN or LOAD_STALL SHALL assert stall_fetch and stall_decode (bubble_exe low) in that cycle, with next state MEM_WAIT.
REQ-011 MEM_WAIT SHALL hold both stalls high while mem_busy_in=1, and SHALL exit the cycle after mem_busy_in drops: to FLUSH if a flush is pending, else RUN.
REQ-012 jump_valid_in=1 in RUN or LOAD_STALL SHALL assert flush_fetch and flush_decode in that cycle, load a 3-bit counter with FLUSH_CYCLES-1, and go to FLUSH (to RUN if FLUSH_CYCLES=1).
REQ-013 FLUSH SHALL keep both flush outputs high and decrement the counter; it SHALL return to RUN when the counter reaches 0, for exactly FLUSH_CYCLES total flush cycles.
REQ-014 Priority for simultaneous events SHALL be: jump > mem_busy > load-use; a jump suppresses stall and bubble outputs in that cycle.
REQ-015 jump_valid_in in MEM_WAIT SHALL set a pending_flush flag, with flush outputs low until MEM_WAIT exits; the flag SHALL clear on entry to FLUSH.
REQ-016 jump_valid_in in FLUSH SHALL reload the counter with FLUSH_CYCLES-1, i.e. restart the flush window.
REQ-017 mem_busy_in in FLUSH SHALL be ignored until FLUSH exits.
REQ-018 stall_count_out SHALL increment by 1 per cycle with stall_decode_out=1, and saturate at all-ones (no wrap).

Reset
REQ-019 rst=1 at a rising edge SHALL force RUN, flush counter 0, pending_flush 0 and stall_count 0, overriding any in-progress stall or flush.
REQ-020 While rst=1, all stall, flush and bubble outputs SHALL be 0; fwd_sel outputs remain combinational.

Structure
REQ-021 State encoding, the fwd_sel enum and forwarding-bus field offsets (valid/rd/data) SHALL live in the shared pipeline package.
REQ-022 Operand-forwarding selection SHALL be one sub-module, forward_select, instantiated twice (rs1, rs2); FSM and counters stay in hazard_controller.

Verification
REQ-023 EXE={1,rd=5,x}, exe_is_load=1, rs1=5 used -> 1 cycle of stall_fetch/stall_decode/bubble_exe, then LOAD_STALL, then RUN; stall_count=1.
REQ-024 EXE rd=3, MEM rd=3, rs2=3 used, not load -> fwd_sel_rs2=1 and no stall; same case with rd=0 -> fwd_sel_rs2=0.
REQ-025 jump_valid for 1 cycle, FLUSH_CYCLES=2 -> flush outputs high for exactly 2 cycles, state RUN on cycle 3.
REQ-026 mem_busy high 3 cycles with jump_valid pulse in the 2nd -> 3 stall cycles, no flush during them, then 2 flush cycles, then RUN.
REQ-027 jump_valid, mem_busy and load-use hazard in the same cycle -> only flush outputs high, state FLUSH.
REQ-028 rst asserted mid-FLUSH and mid-MEM_WAIT -> next cycle RUN, outputs 0, stall_count 0; preloaded saturation at all-ones holds all-ones under further stalls.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM states, forwarding select codes,
// forwarding-bus field layout and the source-match helper.
package hazard_controller_pkg;

    localparam int FWD_BUS_W = 38;
    localparam int VALID_BIT = 37;
    localparam int RD_MSB    = 36;
    localparam int RD_LSB    = 32;
    localparam int DATA_MSB  = 31;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // tag is {valid, rd}; x0 never forwards because it is hardwired to zero
    function automatic logic fwd_match(input logic [5:0] tag, input logic [4:0] rs,
                                       input logic uses);
        return uses && tag[5] && (tag[4:0] != 5'd0) && (tag[4:0] == rs);
    endfunction

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Operand forwarding source selection for one decode source register,
// priority EXE > MEM > WB, falling back to the register file.
module forward_select
    import hazard_controller_pkg::*;
(
    input  logic [FWD_BUS_W-1:0] i_exe_fwd,
    input  logic [FWD_BUS_W-1:0] i_mem_fwd,
    input  logic [FWD_BUS_W-1:0] i_wb_fwd,
    input  logic [4:0]           i_rs,
    input  logic                 i_uses,
    output logic [1:0]           o_sel,
    output logic                 o_exe_match
);

    logic w_exe_hit;
    logic w_mem_hit;
    logic w_wb_hit;
    logic w_unused_data;

    assign w_exe_hit = fwd_match(i_exe_fwd[VALID_BIT:RD_LSB], i_rs, i_uses);
    assign w_mem_hit = fwd_match(i_mem_fwd[VALID_BIT:RD_LSB], i_rs, i_uses);
    assign w_wb_hit  = fwd_match(i_wb_fwd[VALID_BIT:RD_LSB], i_rs, i_uses);

    // data fields are muxed in the datapath, only the tags matter here
    assign w_unused_data = ^{i_exe_fwd[DATA_MSB:DATA_LSB], i_mem_fwd[DATA_MSB:DATA_LSB],
                             i_wb_fwd[DATA_MSB:DATA_LSB]};

    assign o_exe_match = w_exe_hit;

    always_comb begin
        o_sel = FWD_RF;
        if (w_exe_hit)      o_sel = FWD_EXE;
        else if (w_mem_hit) o_sel = FWD_MEM;
        else if (w_wb_hit)  o_sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, memory wait, jump flush and
// stall performance counter, plus operand forwarding selection.
//
// state      | meaning
// LOAD_STALL | one dead cycle after a load-use bubble, no re-detection
// MEM_WAIT   | memory stage busy, fetch/decode held; may carry a pending flush
// FLUSH      | remaining flush cycles after a taken jump, counted by r_flush_cnt
// RUN        | normal flow, hazards detected here
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid_in,
    input  logic [4:0]           dec_rs1_in,
    input  logic [4:0]           dec_rs2_in,
    input  logic                 dec_uses_rs1_in,
    input  logic                 dec_uses_rs2_in,
    input  logic [FWD_BUS_W-1:0] exe_forwarding_in,
    input  logic [FWD_BUS_W-1:0] mem_forwarding_in,
    input  logic [FWD_BUS_W-1:0] wb_forwarding_in,
    input  logic                 exe_is_load_in,
    input  logic                 mem_busy_in,
    input  logic                 jump_valid_in,
    output logic                 stall_fetch_out,
    output logic                 stall_decode_out,
    output logic                 bubble_exe_out,
    output logic                 flush_fetch_out,
    output logic                 flush_decode_out,
    output logic [1:0]           fwd_sel_rs1_out,
    output logic [1:0]           fwd_sel_rs2_out,
    output logic [1:0]           state_out,
    output logic [CNT_WIDTH-1:0] stall_count_out
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    // the jump cycle itself flushes, so a single-cycle window never enters FLUSH
    localparam hz_state_e JUMP_DEST = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;

    hz_state_e             r_state;
    hz_state_e             w_state_nxt;
    logic [2:0]            r_flush_cnt;
    logic [2:0]            w_flush_cnt_nxt;
    logic                  r_pending_flush;
    logic                  w_pending_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_count;
    logic                  w_exe_match_rs1;
    logic                  w_exe_match_rs2;
    logic                  w_load_use;

    forward_select u_fwd_rs1 (
        .i_exe_fwd   (exe_forwarding_in),
        .i_mem_fwd   (mem_forwarding_in),
        .i_wb_fwd    (wb_forwarding_in),
        .i_rs        (dec_rs1_in),
        .i_uses      (dec_uses_rs1_in),
        .o_sel       (fwd_sel_rs1_out),
        .o_exe_match (w_exe_match_rs1)
    );

    forward_select u_fwd_rs2 (
        .i_exe_fwd   (exe_forwarding_in),
        .i_mem_fwd   (mem_forwarding_in),
        .i_wb_fwd    (wb_forwarding_in),
        .i_rs        (dec_rs2_in),
        .i_uses      (dec_uses_rs2_in),
        .o_sel       (fwd_sel_rs2_out),
        .o_exe_match (w_exe_match_rs2)
    );

    assign w_load_use = dec_valid_in & exe_is_load_in & (w_exe_match_rs1 | w_exe_match_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_flush_cnt     <= 3'd0;
            r_pending_flush <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_flush_cnt     <= w_flush_cnt_nxt;
            r_pending_flush <= w_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_pending_nxt   = r_pending_flush;
        case (r_state)
            ST_RUN, ST_LOAD_STALL: begin
                if (jump_valid_in) begin
                    w_flush_cnt_nxt = FLUSH_LOAD;
                    w_state_nxt     = JUMP_DEST;
                end else if (mem_busy_in) begin
                    w_state_nxt = ST_MEM_WAIT;
                end else if ((r_state == ST_RUN) && w_load_use) begin
                    w_state_nxt = ST_LOAD_STALL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy_in) begin
                    if (jump_valid_in) w_pending_nxt = 1'b1;
                end else if (r_pending_flush || jump_valid_in) begin
                    w_pending_nxt   = 1'b0;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                    w_state_nxt     = JUMP_DEST;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (jump_valid_in) begin
                    w_flush_cnt_nxt = FLUSH_LOAD;
                    w_state_nxt     = JUMP_DEST;
                end else if (r_flush_cnt <= 3'd1) begin
                    w_flush_cnt_nxt = 3'd0;
                    w_state_nxt     = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        stall_fetch_out  = 1'b0;
        stall_decode_out = 1'b0;
        bubble_exe_out   = 1'b0;
        flush_fetch_out  = 1'b0;
        flush_decode_out = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN, ST_LOAD_STALL: begin
                    if (jump_valid_in) begin
                        flush_fetch_out  = 1'b1;
                        flush_decode_out = 1'b1;
                    end else if (mem_busy_in) begin
                        stall_fetch_out  = 1'b1;
                        stall_decode_out = 1'b1;
                    end else if ((r_state == ST_RUN) && w_load_use) begin
                        stall_fetch_out  = 1'b1;
                        stall_decode_out = 1'b1;
                        bubble_exe_out   = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy_in) begin
                        stall_fetch_out  = 1'b1;
                        stall_decode_out = 1'b1;
                    end else if (r_pending_flush || jump_valid_in) begin
                        flush_fetch_out  = 1'b1;
                        flush_decode_out = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_fetch_out  = 1'b1;
                    flush_decode_out = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (stall_decode_out && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign state_out       = r_state;
    assign stall_count_out = r_stall_count;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller; a second 2-bit-counter
// instance under constant memory stall exercises counter saturation.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  rs1, rs2;
    logic        uses1, uses2;
    logic [37:0] exe_fwd, mem_fwd, wb_fwd;
    logic        is_load, busy, jump;
    logic        sf, sd, bx, ff, fd;
    logic [1:0]  sel1, sel2, st;
    logic [31:0] cnt;

    logic        b_sf, b_sd, b_bx, b_ff, b_fd;
    logic [1:0]  b_sel1, b_sel2, b_st;
    logic [1:0]  b_cnt;

    logic [4:0]  ctl, b_ctl;
    int          n_total = 0;
    int          n_bad   = 0;

    assign ctl   = {sf, sd, bx, ff, fd};
    assign b_ctl = {b_sf, b_sd, b_bx, b_ff, b_fd};

    always #5 clk = ~clk;

    hazard_controller #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .dec_valid_in(dec_valid),
        .dec_rs1_in(rs1), .dec_rs2_in(rs2),
        .dec_uses_rs1_in(uses1), .dec_uses_rs2_in(uses2),
        .exe_forwarding_in(exe_fwd), .mem_forwarding_in(mem_fwd), .wb_forwarding_in(wb_fwd),
        .exe_is_load_in(is_load), .mem_busy_in(busy), .jump_valid_in(jump),
        .stall_fetch_out(sf), .stall_decode_out(sd), .bubble_exe_out(bx),
        .flush_fetch_out(ff), .flush_decode_out(fd),
        .fwd_sel_rs1_out(sel1), .fwd_sel_rs2_out(sel2),
        .state_out(st), .stall_count_out(cnt)
    );

    hazard_controller #(.FLUSH_CYCLES(2), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .dec_valid_in(1'b0),
        .dec_rs1_in(5'd0), .dec_rs2_in(5'd0),
        .dec_uses_rs1_in(1'b0), .dec_uses_rs2_in(1'b0),
        .exe_forwarding_in(38'd0), .mem_forwarding_in(38'd0), .wb_forwarding_in(38'd0),
        .exe_is_load_in(1'b0), .mem_busy_in(1'b1), .jump_valid_in(1'b0),
        .stall_fetch_out(b_sf), .stall_decode_out(b_sd), .bubble_exe_out(b_bx),
        .flush_fetch_out(b_ff), .flush_decode_out(b_fd),
        .fwd_sel_rs1_out(b_sel1), .fwd_sel_rs2_out(b_sel2),
        .state_out(b_st), .stall_count_out(b_cnt)
    );

    function automatic logic [37:0] fb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        return {v, rd, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; uses1 = 1'b0; uses2 = 1'b0;
        exe_fwd = '0; mem_fwd = '0; wb_fwd = '0;
        is_load = 1'b0; busy = 1'b0; jump = 1'b0;
    endtask

    // advance one clock; inputs change and outputs are sampled 1-2 units after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        // reset gating: a jump and a forwarding match while rst is high
        exe_fwd = fb(1'b1, 5'd4, 32'h1); rs1 = 5'd4; uses1 = 1'b1; jump = 1'b1;
        #1;
        check("rst_ctl", ctl, 5'b00000);
        check("rst_fwd1", sel1, 2'd1);
        tick();
        check("rst_state", st, 2'd0);
        check("rst_cnt", cnt, 32'd0);
        rst = 1'b0;
        idle();

        // forwarding selection
        dec_valid = 1'b1; rs2 = 5'd3; uses2 = 1'b1;
        exe_fwd = fb(1'b1, 5'd3, 32'hA); mem_fwd = fb(1'b1, 5'd3, 32'hB);
        #1;
        check("fwd_exe_mem", sel2, 2'd1);
        check("fwd_no_stall", ctl, 5'b00000);
        exe_fwd = fb(1'b1, 5'd0, 32'hA); mem_fwd = fb(1'b1, 5'd0, 32'hB); rs2 = 5'd0;
        #1;
        check("fwd_rd0", sel2, 2'd0);
        rs1 = 5'd7; uses1 = 1'b1; mem_fwd = fb(1'b1, 5'd7, 32'h0); wb_fwd = fb(1'b1, 5'd7, 32'h0);
        #1;
        check("fwd_mem_wb", sel1, 2'd2);
        mem_fwd = '0;
        #1;
        check("fwd_wb", sel1, 2'd3);
        uses1 = 1'b0;
        #1;
        check("fwd_unused", sel1, 2'd0);
        uses1 = 1'b1; wb_fwd = fb(1'b0, 5'd7, 32'h0);
        #1;
        check("fwd_invalid", sel1, 2'd0);
        tick();
        check("fwd_state", st, 2'd0);
        idle();

        // load-use stall
        dec_valid = 1'b1; exe_fwd = fb(1'b1, 5'd5, 32'h0); is_load = 1'b1;
        rs1 = 5'd5; uses1 = 1'b1;
        #1;
        check("lu_ctl", ctl, 5'b11100);
        check("lu_fwd1", sel1, 2'd1);
        tick();
        check("lu_ls_state", st, 2'd1);
        check("lu_ls_ctl", ctl, 5'b00000);
        idle();
        tick();
        check("lu_run_state", st, 2'd0);
        check("lu_cnt", cnt, 32'd1);

        // plain jump, two flush cycles
        jump = 1'b1;
        #1;
        check("j_c1_ctl", ctl, 5'b00011);
        tick();
        jump = 1'b0;
        #1;
        check("j_c2_state", st, 2'd3);
        check("j_c2_ctl", ctl, 5'b00011);
        tick();
        check("j_c3_state", st, 2'd0);
        check("j_c3_ctl", ctl, 5'b00000);

        // memory wait with a jump during it
        busy = 1'b1;
        #1;
        check("mw_c1_ctl", ctl, 5'b11000);
        tick();
        jump = 1'b1;
        #1;
        check("mw_c2_state", st, 2'd2);
        check("mw_c2_ctl", ctl, 5'b11000);
        tick();
        jump = 1'b0;
        #1;
        check("mw_c3_ctl", ctl, 5'b11000);
        tick();
        busy = 1'b0;
        #1;
        check("mw_exit_state", st, 2'd2);
        check("mw_exit_ctl", ctl, 5'b00011);
        tick();
        check("mw_fl_state", st, 2'd3);
        check("mw_fl_ctl", ctl, 5'b00011);
        tick();
        check("mw_run_state", st, 2'd0);
        check("mw_cnt", cnt, 32'd4);

        // jump inside FLUSH restarts the window
        jump = 1'b1;
        tick();
        check("rj_state", st, 2'd3);
        tick();
        jump = 1'b0;
        #1;
        check("rj_c3_state", st, 2'd3);
        check("rj_c3_ctl", ctl, 5'b00011);
        tick();
        check("rj_c4_state", st, 2'd0);

        // memory busy ignored in FLUSH
        jump = 1'b1;
        tick();
        jump = 1'b0; busy = 1'b1;
        #1;
        check("fb_ctl", ctl, 5'b00011);
        tick();
        check("fb_run_state", st, 2'd0);
        check("fb_run_ctl", ctl, 5'b11000);
        tick();
        busy = 1'b0;
        #1;
        check("fb_mw_ctl", ctl, 5'b00000);
        tick();
        check("fb_end_state", st, 2'd0);
        check("fb_cnt", cnt, 32'd5);

        // all three events together
        dec_valid = 1'b1; exe_fwd = fb(1'b1, 5'd5, 32'h0); is_load = 1'b1;
        rs1 = 5'd5; uses1 = 1'b1; busy = 1'b1; jump = 1'b1;
        #1;
        check("pri_ctl", ctl, 5'b00011);
        tick();
        idle();
        #1;
        check("pri_state", st, 2'd3);
        tick();
        check("pri_end_state", st, 2'd0);

        // memory busy arriving in LOAD_STALL
        dec_valid = 1'b1; exe_fwd = fb(1'b1, 5'd9, 32'h0); is_load = 1'b1;
        rs2 = 5'd9; uses2 = 1'b1;
        tick();
        busy = 1'b1;
        #1;
        check("ls_busy_ctl", ctl, 5'b11000);
        tick();
        idle();
        #1;
        check("ls_busy_state", st, 2'd2);
        tick();
        check("ls_busy_end", st, 2'd0);
        check("ls_busy_cnt", cnt, 32'd7);

        // saturating counter on the narrow instance
        check("sat_cnt", b_cnt, 2'd3);
        check("sat_ctl", b_ctl, 5'b11000);
        tick();
        check("sat_hold", b_cnt, 2'd3);
        check("sat_state", b_st, 2'd2);

        // reset mid-FLUSH
        jump = 1'b1;
        tick();
        jump = 1'b0; rst = 1'b1;
        #1;
        check("rf_ctl", ctl, 5'b00000);
        tick();
        rst = 1'b0;
        #1;
        check("rf_state", st, 2'd0);
        check("rf_cnt", cnt, 32'd0);
        check("rf_ctl2", ctl, 5'b00000);

        // reset mid-MEM_WAIT with a pending flush
        busy = 1'b1;
        tick();
        jump = 1'b1;
        tick();
        jump = 1'b0; rst = 1'b1;
        #1;
        check("rm_ctl", ctl, 5'b00000);
        tick();
        rst = 1'b0; busy = 1'b0;
        #1;
        check("rm_state", st, 2'd0);
        check("rm_cnt", cnt, 32'd0);
        check("rm_ctl2", ctl, 5'b00000);
        tick();
        check("rm_nopend", st, 2'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
